pzhsbus_rr_arbiter: RTL and testbench

Round-robin arbiter multiplexing `REQUESTS` pzhsbus slave streams onto one pzhsbus master stream, with bounded burst grant and a single registered output stage. It sits in front of a shared pzhsbus consumer, e.g. a slicer chain or shared link, and serialises independent producers onto it with fairness and full throughput.

---
 rtl/pzhsbus_rr_arbiter.sv | 145 ++++++++++++++
 tb/tb_pzhsbus_rr_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pzhsbus_rr_arbiter.sv
// pzhsbus_rr_arbiter
//
// Round-robin arbiter that serialises REQUESTS independent pzhsbus producer
// streams onto one pzhsbus consumer stream. A requester that wins keeps the
// grant for up to MAX_BURST consecutive beats while it stays valid. After
// that, the grant rotates. A single registered output stage drives the
// master side, so master valid and payload come straight from flops.
//
// Ports
//   i_clk            clock, all state changes on its rising edge
//   i_rst            synchronous active-high reset
//   slave_valid[i]   requester i has a beat on slave_payload[i]
//   slave_ready[i]   requester i's beat is taken at this edge if valid
//   slave_payload[i] requester i's payload, held stable until accepted
//   master_valid     output register holds a beat
//   master_ready     consumer takes the output beat at this edge
//   master_payload   payload of the output beat
//   o_src            index of the requester that produced the output beat
//   o_grant          one-hot current burst holder, zero when none
module pzhsbus_rr_arbiter #(
    parameter type PAYLOAD   = logic,
    parameter int  REQUESTS  = 2,
    parameter int  MAX_BURST = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [REQUESTS-1:0]           slave_valid,
    output logic [REQUESTS-1:0]           slave_ready,
    input  PAYLOAD                        slave_payload [REQUESTS],
    output logic                          master_valid,
    input  logic                          master_ready,
    output PAYLOAD                        master_payload,
    output logic [$clog2(REQUESTS)-1:0]   o_src,
    output logic [REQUESTS-1:0]           o_grant
);

    localparam int IDX_W = $clog2(REQUESTS);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    // Output register and arbitration state
    logic                out_valid;
    PAYLOAD              out_payload;
    logic [IDX_W-1:0]    out_src;
    logic [REQUESTS-1:0] holder;
    logic [CNT_W-1:0]    burst_cnt;
    logic [IDX_W-1:0]    rr_ptr;

    // Combinational selection results
    logic                load_ok;
    logic                xfer;
    logic                keep_holder;
    logic                sel_found;
    logic [IDX_W-1:0]    sel_idx;
    logic [IDX_W-1:0]    holder_idx;
    logic [IDX_W:0]      scan_sum;

    // The output register can take a new beat when it is empty or being
    // drained in the same cycle.
    assign load_ok = !out_valid || master_ready;

    // Pick this cycle's requester. The holder keeps the grant while it is
    // valid and still under its burst limit; otherwise the scan starts at
    // rr_ptr and wraps. A holder that hit its limit can win again through
    // the scan, which starts a fresh burst instead of leaving a bubble.
    always_comb begin
        holder_idx  = '0;
        keep_holder = 1'b0;
        sel_found   = 1'b0;
        sel_idx     = '0;
        scan_sum    = '0;
        for (int i = 0; i < REQUESTS; i++) begin
            if (holder[i]) begin
                holder_idx = IDX_W'(i);
            end
        end
        if ((|holder) && slave_valid[holder_idx] &&
            (burst_cnt < CNT_W'(MAX_BURST))) begin
            keep_holder = 1'b1;
            sel_found   = 1'b1;
            sel_idx     = holder_idx;
        end else begin
            for (int k = 0; k < REQUESTS; k++) begin
                scan_sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
                if (scan_sum >= (IDX_W + 1)'(REQUESTS)) begin
                    scan_sum = scan_sum - (IDX_W + 1)'(REQUESTS);
                end
                if (!sel_found && slave_valid[scan_sum[IDX_W-1:0]]) begin
                    sel_found = 1'b1;
                    sel_idx   = scan_sum[IDX_W-1:0];
                end
            end
        end
    end

    assign xfer = load_ok && sel_found && !i_rst;

    // Only the selected requester sees ready; reset and a stalled output
    // register force every ready low.
    always_comb begin
        slave_ready = '0;
        if (xfer) begin
            slave_ready[sel_idx] = 1'b1;
        end
    end

    // Output register, burst holder and round-robin pointer. A transfer
    // either extends the current burst or starts a new one of length 1.
    // An idle cycle with room to load ends the burst; a stalled cycle
    // freezes everything.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_valid   <= 1'b0;
            out_payload <= '0;
            out_src     <= '0;
            holder      <= '0;
            burst_cnt   <= '0;
            rr_ptr      <= '0;
        end else if (xfer) begin
            out_valid   <= 1'b1;
            out_payload <= slave_payload[sel_idx];
            out_src     <= sel_idx;
            if (keep_holder) begin
                burst_cnt <= burst_cnt + 1'b1;
            end else begin
                holder    <= REQUESTS'(1) << sel_idx;
                burst_cnt <= CNT_W'(1);
            end
            rr_ptr <= (sel_idx == IDX_W'(REQUESTS - 1)) ? '0 : sel_idx + 1'b1;
        end else begin
            if (master_ready) begin
                out_valid <= 1'b0;
            end
            if (load_ok) begin
                holder    <= '0;
                burst_cnt <= '0;
            end
        end
    end

    assign master_valid   = out_valid;
    assign master_payload = out_payload;
    assign o_src          = out_src;
    assign o_grant        = holder;

endmodule

// File: tb/tb_pzhsbus_rr_arbiter.sv
// tb_pzhsbus_rr_arbiter
//
// Self-checking bench for pzhsbus_rr_arbiter with REQUESTS=3, MAX_BURST=4.
// A behavioural model tracks the holder, burst length and scan start as
// plain integers and predicts readies and the output register every cycle.
// Directed phases cover reset, burst rotation, backpressure, early release,
// a lone requester and reset mid-stream; a random phase runs in between.
module tb_pzhsbus_rr_arbiter;

    localparam int REQ   = 3;
    localparam int BURST = 4;

    logic             i_clk;
    logic             i_rst;
    logic [REQ-1:0]   slave_valid;
    logic [REQ-1:0]   slave_ready;
    logic [7:0]       slave_payload [REQ];
    logic             master_valid;
    logic             master_ready;
    logic [7:0]       master_payload;
    logic [1:0]       o_src;
    logic [REQ-1:0]   o_grant;

    pzhsbus_rr_arbiter #(
        .PAYLOAD   (logic [7:0]),
        .REQUESTS  (REQ),
        .MAX_BURST (BURST)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .slave_valid    (slave_valid),
        .slave_ready    (slave_ready),
        .slave_payload  (slave_payload),
        .master_valid   (master_valid),
        .master_ready   (master_ready),
        .master_payload (master_payload),
        .o_src          (o_src),
        .o_grant        (o_grant)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;

    // Producer side: one pending beat per requester, refilled after acceptance
    // while beats_left is non-zero (-1 means endless).
    logic [REQ-1:0]   src_valid;
    logic [7:0]       src_payload [REQ];
    int               seq [REQ];
    int               beats_left [REQ];

    // Reference model state
    logic             model_known;
    logic             m_out_valid;
    logic [7:0]       m_out_payload;
    int               m_out_src;
    int               m_holder;
    int               m_cnt;
    int               m_ptr;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic new_beat(input int i);
        seq[i]++;
        src_valid[i]   = 1'b1;
        src_payload[i] = 8'((i << 6) | (seq[i] & 63));
    endtask

    // Raise requester i for n beats in total (n < 0: endless).
    task automatic raise(input int i, input int n);
        new_beat(i);
        beats_left[i] = (n < 0) ? -1 : n - 1;
    endtask

    function automatic int model_select();
        if (m_holder >= 0 && src_valid[m_holder] && m_cnt < BURST) return m_holder;
        for (int k = 0; k < REQ; k++) begin
            if (src_valid[(m_ptr + k) % REQ]) return (m_ptr + k) % REQ;
        end
        return -1;
    endfunction

    function automatic logic [REQ-1:0] onehot_of(input int idx);
        logic [REQ-1:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    // One clock cycle: drive inputs, compare combinational readies and the
    // registered outputs against the model, advance the model, cross the edge.
    task automatic apply_stimulus(input logic rst, input logic mready);
        int             sel;
        logic           load_ok;
        logic [REQ-1:0] exp_ready;
        i_rst        = rst;
        master_ready = mready;
        slave_valid  = src_valid;
        for (int i = 0; i < REQ; i++) slave_payload[i] = src_payload[i];
        #1;
        load_ok   = !m_out_valid || mready;
        sel       = model_select();
        exp_ready = '0;
        if (!rst && model_known && load_ok && sel >= 0) exp_ready[sel] = 1'b1;
        if (model_known || rst) check_output("slave_ready", 32'(slave_ready), 32'(exp_ready));
        if (model_known) begin
            check_output("master_valid", 32'(master_valid), 32'(m_out_valid));
            check_output("o_grant", 32'(o_grant), 32'(onehot_of(m_holder)));
            if (m_out_valid) begin
                check_output("master_payload", 32'(master_payload), 32'(m_out_payload));
                check_output("o_src", 32'(o_src), 32'(m_out_src));
            end
        end
        if (rst) begin
            model_known = 1'b1;
            m_out_valid = 1'b0;
            m_holder    = -1;
            m_cnt       = 0;
            m_ptr       = 0;
        end else if (model_known) begin
            if (load_ok && sel >= 0) begin
                m_out_valid   = 1'b1;
                m_out_payload = src_payload[sel];
                m_out_src     = sel;
                if (sel == m_holder && m_cnt < BURST) begin
                    m_cnt++;
                end else begin
                    m_holder = sel;
                    m_cnt    = 1;
                end
                m_ptr = (sel + 1) % REQ;
                if (beats_left[sel] == 0) begin
                    src_valid[sel] = 1'b0;
                end else begin
                    new_beat(sel);
                    if (beats_left[sel] > 0) beats_left[sel]--;
                end
            end else begin
                if (m_out_valid && mready) m_out_valid = 1'b0;
                if (load_ok) begin
                    m_holder = -1;
                    m_cnt    = 0;
                end
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    // Stop refilling, let pending beats flow out, then idle so the holder clears.
    task automatic drain();
        for (int i = 0; i < REQ; i++) beats_left[i] = 0;
        for (int n = 0; n < 20 && src_valid != '0; n++) apply_stimulus(1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] held;
        i_rst        = 1'b1;
        master_ready = 1'b0;
        slave_valid  = '0;
        src_valid    = '0;
        model_known  = 1'b0;
        m_out_valid  = 1'b0;
        m_out_payload = '0;
        m_out_src    = 0;
        m_holder     = -1;
        m_cnt        = 0;
        m_ptr        = 0;
        for (int i = 0; i < REQ; i++) begin
            seq[i]           = 0;
            beats_left[i]    = 0;
            src_payload[i]   = '0;
            slave_payload[i] = '0;
        end

        // Reset for two cycles with every requester valid
        for (int i = 0; i < REQ; i++) raise(i, -1);
        apply_stimulus(1'b1, 1'b1);
        apply_stimulus(1'b1, 1'b1);
        check_output("reset_master_valid", 32'(master_valid), 32'd0);
        check_output("reset_grant", 32'(o_grant), 32'd0);

        // Burst rotation with everyone valid: 0,0,0,0,1,1,1,1,2,2,2,2,0,0
        for (int k = 0; k < 14; k++) begin
            apply_stimulus(1'b0, 1'b1);
            check_output("burst_valid", 32'(master_valid), 32'd1);
            check_output("burst_src", 32'(o_src), 32'((k / 4) % 3));
            check_output("burst_grant", 32'(o_grant), 32'(1 << ((k / 4) % 3)));
        end

        // Backpressure: output held, then sequence resumes where it stopped
        held = master_payload;
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(1'b0, 1'b0);
            check_output("stall_valid", 32'(master_valid), 32'd1);
            check_output("stall_payload", 32'(master_payload), 32'(held));
        end
        for (int k = 14; k < 17; k++) begin
            apply_stimulus(1'b0, 1'b1);
            check_output("resume_src", 32'(o_src), 32'((k / 4) % 3));
        end
        drain();

        // Early release: requester 1 sends two beats, then 2 takes over
        raise(1, 2);
        apply_stimulus(1'b0, 1'b1);
        check_output("early_src_a", 32'(o_src), 32'd1);
        raise(2, -1);
        apply_stimulus(1'b0, 1'b1);
        check_output("early_src_b", 32'(o_src), 32'd1);
        apply_stimulus(1'b0, 1'b1);
        check_output("early_src_c", 32'(o_src), 32'd2);
        check_output("early_grant", 32'(o_grant), 32'b100);
        raise(1, -1);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b0, 1'b1);
            check_output("early_wait_src", 32'(o_src), 32'd2);
        end
        apply_stimulus(1'b0, 1'b1);
        check_output("early_back_src", 32'(o_src), 32'd1);
        drain();

        // Lone requester: ten back-to-back beats, no bubble across burst limit
        raise(2, 10);
        for (int k = 0; k < 10; k++) begin
            apply_stimulus(1'b0, 1'b1);
            check_output("lone_valid", 32'(master_valid), 32'd1);
            check_output("lone_src", 32'(o_src), 32'd2);
            check_output("lone_grant", 32'(o_grant), 32'b100);
        end
        apply_stimulus(1'b0, 1'b1);
        check_output("lone_end_valid", 32'(master_valid), 32'd0);
        check_output("lone_end_grant", 32'(o_grant), 32'd0);

        // Random traffic and backpressure against the model
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < REQ; i++) begin
                if (!src_valid[i] && $urandom_range(0, 2) == 0)
                    raise(i, int'($urandom_range(1, 6)));
            end
            apply_stimulus(1'b0, ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
        end

        // Reset mid-stream with a stalled full output register
        for (int i = 0; i < REQ; i++) begin
            if (!src_valid[i]) raise(i, -1);
            else beats_left[i] = -1;
        end
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0);
        check_output("midrst_valid", 32'(master_valid), 32'd0);
        check_output("midrst_grant", 32'(o_grant), 32'd0);
        apply_stimulus(1'b0, 1'b1);
        check_output("midrst_first_src", 32'(o_src), 32'd0);
        check_output("midrst_first_valid", 32'(master_valid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
